traffic_monitor: RTL

- Passive checker and decoder on the car/walker light buses driven by the traffic-light controller.
- Decodes the one-hot car code and the 2-bit walker code, and measures how many cycles each car phase lasts.
- Flags illegal codes, illegal phase sequences, too-short phases and car/walker conflicts.
- Counts completed signal cycles (red->green transitions).
- Sits beside the controller in the top level; drives status and error outputs only, never the lights.

---
 rtl/traffic_monitor.sv | 121 ++++++++++++
 1 files changed

// File: rtl/traffic_monitor.sv
// Passive monitor for the car/walker light buses: decodes the codes, measures car phase
// lengths, counts red->green cycles and raises sticky error flags. Drives no lights.
module traffic_monitor #(
   parameter int CNT_W   = 7,
   parameter int MIN_LEN = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_enable,
   input  logic             i_clear,
   input  logic [3:0]       i_car_traffic,
   input  logic [1:0]       i_walker_traffic,
   output logic             o_phase_done,
   output logic [3:0]       o_last_phase,
   output logic [CNT_W-1:0] o_last_len,
   output logic [7:0]       o_cycle_cnt,
   output logic             o_err_code,
   output logic             o_err_seq,
   output logic             o_err_short,
   output logic             o_err_conflict
);

   localparam logic [3:0] CAR_NONE   = 4'b0000;
   localparam logic [3:0] CAR_GREEN  = 4'b0001;
   localparam logic [3:0] CAR_LEFT   = 4'b0010;
   localparam logic [3:0] CAR_YELLOW = 4'b0100;
   localparam logic [3:0] CAR_RED    = 4'b1000;

   localparam logic [1:0] WALK_GREEN = 2'b01;
   localparam logic [1:0] WALK_BAD   = 2'b11;

   localparam logic [CNT_W-1:0] LEN_MAX = '1;
   localparam logic [CNT_W-1:0] LEN_MIN = CNT_W'(MIN_LEN);

   logic [3:0]       r_prev;
   logic [CNT_W-1:0] r_len;

   logic       car_legal;
   logic [3:0] cur;
   logic       trans_legal;
   logic       phase_end;
   logic       code_err;
   logic       seq_err;
   logic       short_err;
   logic       conflict_err;
   logic       red_to_green;

   // NOTE: every signal gets a default at the top of always_comb so no path can infer a latch.
   always_comb begin
      car_legal   = 1'b0;
      trans_legal = 1'b0;
      case (i_car_traffic)
         CAR_NONE, CAR_GREEN, CAR_LEFT, CAR_YELLOW, CAR_RED: car_legal = 1'b1;
         default:                                            car_legal = 1'b0;
      endcase

      // An illegal car code is tracked as if the lights were dark.
      cur = car_legal ? i_car_traffic : CAR_NONE;

      case ({r_prev, cur})
         {CAR_GREEN,  CAR_YELLOW},
         {CAR_YELLOW, CAR_LEFT},
         {CAR_YELLOW, CAR_RED},
         {CAR_LEFT,   CAR_YELLOW},
         {CAR_RED,    CAR_GREEN}: trans_legal = 1'b1;
         default:                 trans_legal = 1'b0;
      endcase

      phase_end    = i_enable && (cur != r_prev) && (r_prev != CAR_NONE);
      code_err     = i_enable && (!car_legal || (i_walker_traffic == WALK_BAD));
      seq_err      = phase_end && (cur != CAR_NONE) && !trans_legal;
      short_err    = phase_end && (r_len < LEN_MIN);
      conflict_err = i_enable && (i_walker_traffic == WALK_GREEN) &&
                     ((cur == CAR_GREEN) || (cur == CAR_LEFT));
      red_to_green = i_enable && (r_prev == CAR_RED) && (cur == CAR_GREEN);
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_prev         <= CAR_NONE;
         r_len          <= '0;
         o_phase_done   <= 1'b0;
         o_last_phase   <= CAR_NONE;
         o_last_len     <= '0;
         o_cycle_cnt    <= '0;
         o_err_code     <= 1'b0;
         o_err_seq      <= 1'b0;
         o_err_short    <= 1'b0;
         o_err_conflict <= 1'b0;
      end else begin
         // A new error in the same cycle as i_clear wins over the clear.
         o_err_code     <= (o_err_code     & ~i_clear) | code_err;
         o_err_seq      <= (o_err_seq      & ~i_clear) | seq_err;
         o_err_short    <= (o_err_short    & ~i_clear) | short_err;
         o_err_conflict <= (o_err_conflict & ~i_clear) | conflict_err;

         if (i_enable) begin
            r_prev       <= cur;
            o_phase_done <= phase_end;
            if (phase_end) begin
               o_last_phase <= r_prev;
               o_last_len   <= r_len;
            end
            if (cur == CAR_NONE)
               r_len <= '0;
            else if (cur != r_prev)
               r_len <= CNT_W'(1);
            else if (r_len != LEN_MAX)
               r_len <= r_len + CNT_W'(1);
            if (red_to_green)
               o_cycle_cnt <= o_cycle_cnt + 8'd1;
         end else begin
            // Forgetting the previous code means re-enabling never closes a stale phase.
            r_prev       <= CAR_NONE;
            o_phase_done <= 1'b0;
         end
      end
   end

endmodule
